// File: rtl/turn_sequencer_if.sv
// Board-side bundle for the N-player dice turn sequencer: debounced inputs in, game status out.
// The slave modport is the sequencer's view; master is the board/display side.
interface turn_sequencer_if #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SCORE_W     = 7,
  parameter int unsigned DIE_W       = 3
);
  localparam int unsigned PW = $clog2(NUM_PLAYERS);

  logic                         power;
  logic                         roll_btn;
  logic [DIE_W-1:0]             die_value;
  logic [1:0]                   state;
  logic [PW-1:0]                cur_player;
  logic [NUM_PLAYERS*SCORE_W-1:0] scores;
  logic                         roll_ack;
  logic                         bad_roll;
  logic [PW-1:0]                winner;
  logic                         winner_valid;

  modport slave (
    input  power, roll_btn, die_value,
    output state, cur_player, scores, roll_ack, bad_roll, winner, winner_valid
  );

  modport master (
    output power, roll_btn, die_value,
    input  state, cur_player, scores, roll_ack, bad_roll, winner, winner_valid
  );
endinterface

// File: rtl/turn_sequencer.sv
// N-player dice turn controller: press detect, die latch, per-player scoring, rotation and win.
// Optional macro EXTRA_ROLL_EN grants a bonus turn on a scored non-winning roll of 6.
module turn_sequencer #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SCORE_W     = 7,
  parameter int unsigned WIN_SCORE   = 50,
  parameter int unsigned DIE_W       = 3
) (
  input logic                clk,
  input logic                reset,
  turn_sequencer_if.slave    bus
);
  localparam int unsigned PW = $clog2(NUM_PLAYERS);
  localparam logic [DIE_W-1:0]   DieMax    = DIE_W'(6);
  localparam logic [SCORE_W:0]   WinThresh = (SCORE_W + 1)'(WIN_SCORE);
  localparam logic [PW-1:0]      LastPlayer = PW'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {
    StOff   = 2'b00,
    StTurn  = 2'b01,
    StScore = 2'b10,
    StDone  = 2'b11
  } state_e;

  state_e                                state_q, state_d;
  logic [PW-1:0]                         cur_q, cur_d;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0]   scores_q, scores_d;
  logic [DIE_W-1:0]                      roll_q, roll_d;
  logic                                  roll_prev_q;
  logic                                  ack_q, ack_d;
  logic                                  bad_q, bad_d;
  logic [PW-1:0]                         winner_q, winner_d;
  logic                                  winner_valid_q, winner_valid_d;

  logic                                  press;
  logic                                  die_ok;
  logic [SCORE_W:0]                      sum;
  logic [SCORE_W-1:0]                    sum_sat;

  assign press   = ~bus.roll_btn & roll_prev_q;
  assign die_ok  = (bus.die_value != '0) && (bus.die_value <= DieMax);
  assign sum     = {1'b0, scores_q[cur_q]} + (SCORE_W + 1)'(roll_q);
  assign sum_sat = sum[SCORE_W] ? '1 : sum[SCORE_W-1:0];

  always_comb begin
    state_d        = state_q;
    cur_d          = cur_q;
    scores_d       = scores_q;
    roll_d         = roll_q;
    ack_d          = 1'b0;
    bad_d          = 1'b0;
    winner_d       = winner_q;
    winner_valid_d = winner_valid_q;

    if (!bus.power) begin
      state_d = StOff;
    end else begin
      unique case (state_q)
        StOff: begin
          // Powering up starts a fresh game.
          state_d        = StTurn;
          scores_d       = '0;
          cur_d          = '0;
          winner_d       = '0;
          winner_valid_d = 1'b0;
        end
        StTurn: begin
          if (press) begin
            if (die_ok) begin
              roll_d  = bus.die_value;
              state_d = StScore;
            end else begin
              bad_d = 1'b1;
            end
          end
        end
        StScore: begin
          scores_d[cur_q] = sum_sat;
          ack_d           = 1'b1;
          if (sum >= WinThresh) begin
            state_d        = StDone;
            winner_d       = cur_q;
            winner_valid_d = 1'b1;
          end else begin
            state_d = StTurn;
`ifdef EXTRA_ROLL_EN
            if (roll_q != DieMax) begin
              cur_d = (cur_q == LastPlayer) ? '0 : cur_q + PW'(1);
            end
`else
            cur_d = (cur_q == LastPlayer) ? '0 : cur_q + PW'(1);
`endif
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: state_d = StOff;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= StOff;
      cur_q          <= '0;
      scores_q       <= '0;
      roll_q         <= '0;
      roll_prev_q    <= 1'b1;
      ack_q          <= 1'b0;
      bad_q          <= 1'b0;
      winner_q       <= '0;
      winner_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_q          <= cur_d;
      scores_q       <= scores_d;
      roll_q         <= roll_d;
      roll_prev_q    <= bus.roll_btn;
      ack_q          <= ack_d;
      bad_q          <= bad_d;
      winner_q       <= winner_d;
      winner_valid_q <= winner_valid_d;
    end
  end

  assign bus.state        = state_q;
  assign bus.cur_player   = cur_q;
  assign bus.scores       = scores_q;
  assign bus.roll_ack     = ack_q;
  assign bus.bad_roll     = bad_q;
  assign bus.winner       = winner_q;
  assign bus.winner_valid = winner_valid_q;
endmodule

// File: tb/tb_turn_sequencer.sv
// Scoreboard bench for turn_sequencer with three players: directed presses push expected
// status snapshots; a monitor pops and compares on every roll_ack / bad_roll pulse.
module tb_turn_sequencer;
  localparam int NP = 3;
  localparam int SW = 7;
  localparam int DW = 3;

  typedef struct {
    logic [1:0] st;
    logic [1:0] cur;
    logic [6:0] s0;
    logic [6:0] s1;
    logic [6:0] s2;
    logic       wv;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_pass = 0;
  int   n_total = 0;
  exp_t ack_q[$];
  exp_t bad_q[$];

  turn_sequencer_if #(.NUM_PLAYERS(NP), .SCORE_W(SW), .DIE_W(DW)) bus ();

  turn_sequencer #(
    .NUM_PLAYERS(NP),
    .SCORE_W    (SW),
    .WIN_SCORE  (50),
    .DIE_W      (DW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  function automatic logic [6:0] sc(input int p);
    return bus.scores[p*SW +: SW];
  endfunction

  function automatic exp_t mk(input int st, input int cur, input int s0, input int s1,
                              input int s2, input int wv);
    exp_t e;
    e.st = 2'(st); e.cur = 2'(cur); e.s0 = 7'(s0); e.s1 = 7'(s1); e.s2 = 7'(s2);
    e.wv = 1'(wv);
    return e;
  endfunction

  task automatic cmp_snapshot(input string tag, input exp_t e);
    chk({tag, "_state"}, 32'(bus.state), 32'(e.st));
    chk({tag, "_cur"}, 32'(bus.cur_player), 32'(e.cur));
    chk({tag, "_s0"}, 32'(sc(0)), 32'(e.s0));
    chk({tag, "_s1"}, 32'(sc(1)), 32'(e.s1));
    chk({tag, "_s2"}, 32'(sc(2)), 32'(e.s2));
    chk({tag, "_winner_valid"}, 32'(bus.winner_valid), 32'(e.wv));
    if (e.wv) chk({tag, "_winner"}, 32'(bus.winner), 32'(e.cur));
  endtask

  // Monitor: every output pulse must be matched by a queued expectation.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.roll_ack) begin
        if (ack_q.size() == 0) chk("unexpected_roll_ack", 32'(bus.roll_ack), 32'd0);
        else cmp_snapshot("ack", ack_q.pop_front());
      end
      if (bus.bad_roll) begin
        if (bad_q.size() == 0) chk("unexpected_bad_roll", 32'(bus.bad_roll), 32'd0);
        else cmp_snapshot("bad", bad_q.pop_front());
      end
    end
  end

  // kind: 0 = no response expected, 1 = roll_ack, 2 = bad_roll
  task automatic press(input int die, input int hold, input int kind, input exp_t e);
    @(negedge clk);
    bus.die_value = DW'(die);
    bus.roll_btn  = 1'b0;
    if (kind == 1) ack_q.push_back(e);
    if (kind == 2) bad_q.push_back(e);
    repeat (hold) @(negedge clk);
    bus.roll_btn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int budget = 10;
    while ((ack_q.size() != 0 || bad_q.size() != 0) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk({tag, "_pending"}, 32'(ack_q.size() + bad_q.size()), 32'd0);
  endtask

  task automatic set_power(input logic p);
    @(negedge clk);
    bus.power = p;
    @(negedge clk);
  endtask

  initial begin
    int s0, s1, s2, d0;
    reset        = 1'b1;
    bus.power    = 1'b0;
    bus.roll_btn = 1'b1;
    bus.die_value = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_cur", 32'(bus.cur_player), 32'd0);
    chk("reset_scores", 32'(bus.scores), 32'd0);
    chk("reset_ack", 32'(bus.roll_ack), 32'd0);
    chk("reset_bad", 32'(bus.bad_roll), 32'd0);
    chk("reset_wv", 32'(bus.winner_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("off_hold", 32'(bus.state), 32'd0);
    set_power(1'b1);
    chk("power_on_turn", 32'(bus.state), 32'd1);
    chk("power_on_cur", 32'(bus.cur_player), 32'd0);

    // Rotation: dice 4,5,2,3
    press(4, 1, 1, mk(1, 1, 4, 0, 0, 0));
    press(5, 1, 1, mk(1, 2, 4, 5, 0, 0));
    press(2, 1, 1, mk(1, 0, 4, 5, 2, 0));
    press(3, 1, 1, mk(1, 1, 7, 5, 2, 0));
    drain("rotation");

    // Key held low 10 cycles -> one roll only
    press(3, 10, 1, mk(1, 2, 7, 8, 2, 0));
    drain("hold");

    // Illegal faces
    press(0, 1, 2, mk(1, 2, 7, 8, 2, 0));
    press(7, 1, 2, mk(1, 2, 7, 8, 2, 0));
    drain("bad");
    chk("bad_state", 32'(bus.state), 32'd1);
    chk("bad_s2", 32'(sc(2)), 32'd2);

    // Power drop holds scores; power-up clears them
    set_power(1'b0);
    chk("pwr_off_state", 32'(bus.state), 32'd0);
    chk("pwr_off_s1_held", 32'(sc(1)), 32'd8);
    press(4, 1, 0, mk(0, 0, 0, 0, 0, 0));
    chk("pwr_off_press_ignored", 32'(bus.state), 32'd0);
    set_power(1'b1);
    chk("new_game_scores", 32'(bus.scores), 32'd0);
    chk("new_game_cur", 32'(bus.cur_player), 32'd0);

`ifdef EXTRA_ROLL_EN
    press(6, 1, 1, mk(1, 0, 6, 0, 0, 0));
`else
    press(6, 1, 1, mk(1, 1, 6, 0, 0, 0));
`endif
    drain("six");

    set_power(1'b0);
    set_power(1'b1);
    chk("game3_scores", 32'(bus.scores), 32'd0);

    // Bring p0 to 48 with no sixes, others rolling 1
    s0 = 0; s1 = 0; s2 = 0;
    for (int r = 0; r < 10; r++) begin
      d0 = (r < 9) ? 5 : 3;
      s0 += d0;
      press(d0, 1, 1, mk(1, 1, s0, s1, s2, 0));
      s1 += 1;
      press(1, 1, 1, mk(1, 2, s0, s1, s2, 0));
      s2 += 1;
      press(1, 1, 1, mk(1, 0, s0, s1, s2, 0));
    end
    drain("climb");
    chk("climb_s0", 32'(sc(0)), 32'd48);

    // 48 + 2 reaches the win threshold exactly
    press(2, 1, 1, mk(3, 0, 50, 10, 10, 1));
    drain("win");
    press(4, 1, 0, mk(0, 0, 0, 0, 0, 0));
    chk("done_state", 32'(bus.state), 32'd3);
    chk("done_s0", 32'(sc(0)), 32'd50);
    chk("done_winner", 32'(bus.winner), 32'd0);
    chk("done_wv", 32'(bus.winner_valid), 32'd1);

    set_power(1'b0);
    set_power(1'b1);
    chk("restart_state", 32'(bus.state), 32'd1);
    chk("restart_scores", 32'(bus.scores), 32'd0);
    chk("restart_wv", 32'(bus.winner_valid), 32'd0);

    drain("final");
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
